// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file write-back sequencer.
package regwb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_if.sv
// Producer handshakes, register-file write port, forwarding and queue status.
interface regwb_if #(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                          mem_valid;
  logic                          mem_ready;
  logic [regwb_pkg::ADDR_W-1:0]  mem_reg;
  logic [regwb_pkg::DATA_W-1:0]  mem_data;
  logic                          alu_valid;
  logic                          alu_ready;
  logic [regwb_pkg::ADDR_W-1:0]  alu_reg;
  logic [regwb_pkg::DATA_W-1:0]  alu_data;
  logic                          RegWrite;
  logic [regwb_pkg::ADDR_W-1:0]  writeReg;
  logic [regwb_pkg::DATA_W-1:0]  writeData;
  logic [regwb_pkg::ADDR_W-1:0]  readReg1;
  logic [regwb_pkg::ADDR_W-1:0]  readReg2;
  logic                          fwd1_hit;
  logic                          fwd2_hit;
  logic [regwb_pkg::DATA_W-1:0]  fwd1_data;
  logic [regwb_pkg::DATA_W-1:0]  fwd2_data;
  logic [CntW-1:0]               count;
  logic                          full;
  logic                          empty;

  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, readReg1, readReg2,
    input  mem_ready, alu_ready, RegWrite, writeReg, writeData,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count, full, empty
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, readReg1, readReg2,
    output mem_ready, alu_ready, RegWrite, writeReg, writeData,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count, full, empty
  );

endinterface

// File: rtl/regwb_fifo.sv
// In-order circular buffer of pending writes with a two-port newest-match search.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         pushEntry,
  input  logic              pop,
  output wb_entry_t         headEntry,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] searchAddr1,
  input  logic [ADDR_W-1:0] searchAddr2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] hitData1,
  output logic [DATA_W-1:0] hitData2
);

  wb_entry_t       mem [DEPTH];
  logic [PtrW-1:0] headQ, tailQ;
  logic [CntW-1:0] cntQ;
  logic            pushOk, popOk;

  assign full   = (cntQ == CntW'(DEPTH));
  assign empty  = (cntQ == '0);
  assign count  = cntQ;
  assign pushOk = push & ~full;
  assign popOk  = pop & ~empty;

  // Gated so the write port reads zero whenever nothing is queued, including in reset.
  assign headEntry = empty ? '0 : mem[headQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headQ <= '0;
      tailQ <= '0;
      cntQ  <= '0;
    end else begin
      if (pushOk) tailQ <= tailQ + 1'b1;
      if (popOk)  headQ <= headQ + 1'b1;
      if (pushOk && !popOk)      cntQ <= cntQ + 1'b1;
      else if (popOk && !pushOk) cntQ <= cntQ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[tailQ] <= pushEntry;
  end

  // Walk from head to tail so later (newer) matches override earlier ones.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx      = '0;
    hit1     = 1'b0;
    hit2     = 1'b0;
    hitData1 = '0;
    hitData2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = headQ + PtrW'(i);
      if (CntW'(i) < cntQ) begin
        if (searchAddr1 != ZERO_REG && mem[idx].dest == searchAddr1) begin
          hit1     = 1'b1;
          hitData1 = mem[idx].data;
        end
        if (searchAddr2 != ZERO_REG && mem[idx].dest == searchAddr2) begin
          hit2     = 1'b1;
          hitData2 = mem[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back sequencer: arbitrates load/ALU writes, drops r0, retires one write per cycle.
module regfile_writeback
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  regwb_if.slave bus
);

  logic      memAccept, aluAccept, push, full, empty;
  wb_entry_t reqEntry, headEntry;

  assign bus.mem_ready = ~rst & ~full;
  assign bus.alu_ready = ~rst & ~full & ~bus.mem_valid;

  assign memAccept = bus.mem_valid & bus.mem_ready;
  assign aluAccept = bus.alu_valid & bus.alu_ready;

  always_comb begin
    reqEntry = '0;
    if (memAccept) begin
      reqEntry.dest = bus.mem_reg;
      reqEntry.data = bus.mem_data;
    end else if (aluAccept) begin
      reqEntry.dest = bus.alu_reg;
      reqEntry.data = bus.alu_data;
    end
  end

  // Writes to r0 complete the handshake but are never queued.
  assign push = (memAccept | aluAccept) & (reqEntry.dest != ZERO_REG);

  regwb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pushEntry   (reqEntry),
    .pop         (~empty),
    .headEntry   (headEntry),
    .count       (bus.count),
    .full        (full),
    .empty       (empty),
    .searchAddr1 (bus.readReg1),
    .searchAddr2 (bus.readReg2),
    .hit1        (bus.fwd1_hit),
    .hit2        (bus.fwd2_hit),
    .hitData1    (bus.fwd1_data),
    .hitData2    (bus.fwd2_data)
  );

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.RegWrite  = ~empty;
  assign bus.writeReg  = headEntry.dest;
  assign bus.writeData = headEntry.data;

endmodule
